// File: rtl/btn_evt_pkg.sv
// Shared definitions for the button event decoder: FSM state encoding and
// default timing constants for a 100 MHz system clock.
package btn_evt_pkg;

  // FSM states. 2'd3 is unused and recovers to S_IDLE.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRESS = 2'd1,
    S_HOLD  = 2'd2
  } btn_state_e;

  localparam int unsigned CLK_HZ = 100_000_000;

  // Converts a duration in milliseconds into clk cycles at CLK_HZ.
  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return ms * (CLK_HZ / 1000);
  endfunction

  // 500 ms long-press threshold, 100 ms auto-repeat period.
  localparam int unsigned DEF_LONG_CYCLES   = ms_to_cycles(500);
  localparam int unsigned DEF_REPEAT_CYCLES = ms_to_cycles(100);

  // Timer width able to hold max(DEF_LONG_CYCLES, DEF_REPEAT_CYCLES) - 1.
  localparam int DEF_CNT_W = 26;

endpackage

// File: rtl/button_event_decoder_edge_detect.sv
// Edge detector for a clk-synchronous level. The level is registered twice;
// rise/fall compare the two registered samples so that every downstream event
// lines up one cycle after the sampling edge. RST_VAL sets what the detector
// believes the input was before reset release: with RST_VAL=1 a level that is
// already high when reset releases produces no rise.
module edge_detect #(
  parameter bit RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q;
  logic sig_qq;

  // Two-stage sample of the input level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q  <= RST_VAL;
      sig_qq <= RST_VAL;
    end else begin
      sig_q  <= sig_i;
      sig_qq <= sig_q;
    end
  end

  assign rise_o = sig_q & ~sig_qq;
  assign fall_o = ~sig_q & sig_qq;

endmodule

// File: rtl/button_event_decoder.sv
// Turns a clean, synchronous button level into one-cycle event pulses:
// press, release, short click, long press and auto-repeat while held, plus a
// wrapping 8-bit press counter. All outputs are registered.
module button_event_decoder
  import btn_evt_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter bit          REPEAT_EN     = 1'b1,
  parameter int          CNT_W         = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       short_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic       held,
  output logic [7:0] press_count
);

  // Terminal timer values; the timer is cleared on reaching them, so it never wraps.
  localparam logic [CNT_W-1:0] LONG_TERM   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_CYCLES - 1);

  logic rise;
  logic fall;

  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [7:0]       count_q, count_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             held_q, held_d;

  // Button assumed pressed before reset release, so a held button yields no press.
  edge_detect #(
    .RST_VAL (1'b1)
  ) u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (btn),
    .rise_o (rise),
    .fall_o (fall)
  );

  // Next-state, timer and event decode. A fall always wins over a terminal count.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    count_d   = count_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (rise) begin
          state_d = S_PRESS;
          press_d = 1'b1;
          count_d = count_q + 8'd1;
        end
      end

      S_PRESS: begin
        if (fall) begin
          state_d   = S_IDLE;
          timer_d   = '0;
          release_d = 1'b1;
          short_d   = 1'b1;
        end else if (timer_q == LONG_TERM) begin
          state_d = S_HOLD;
          timer_d = '0;
          long_d  = 1'b1;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end

      S_HOLD: begin
        if (fall) begin
          state_d   = S_IDLE;
          timer_d   = '0;
          release_d = 1'b1;
        end else if (timer_q == REPEAT_TERM) begin
          timer_d  = '0;
          repeat_d = REPEAT_EN;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase

    held_d = (state_d != S_IDLE);
  end

  // State, timer, counter and registered event outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      count_q   <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      count_q   <= count_d;
      press_q   <= press_d;
      release_q <= release_d;
      short_q   <= short_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign short_pulse   = short_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;
  assign held          = held_q;
  assign press_count   = count_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder with LONG_CYCLES=8, REPEAT_CYCLES=4.
// Expected pulses are queued (cycle stamp + kind) as stimulus is driven and
// matched against observed pulses each cycle. A second instance with
// REPEAT_EN=0 covers the no-repeat configuration.
`timescale 1ns/1ps
module tb_button_event_decoder;

  localparam int LONG = 8;
  localparam int REP  = 4;

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_SHORT = 2;
  localparam int K_LONG  = 3;
  localparam int K_REP   = 4;

  typedef struct {
    int cyc;
    int kind;
  } ev_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn   = 1'b0;
  logic       btn2  = 1'b0;

  logic       press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held;
  logic [7:0] press_count;
  logic       p2, r2, s2, l2, rp2, h2;
  logic [7:0] c2;

  ev_t exp_q[$];
  int  ecnt = 0;
  int  nvec = 0;
  int  nerr = 0;
  int  n2[5];

  always #5 clk = ~clk;

  button_event_decoder #(
    .LONG_CYCLES   (LONG),
    .REPEAT_CYCLES (REP),
    .REPEAT_EN     (1'b1),
    .CNT_W         (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn           (btn),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .short_pulse   (short_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse),
    .held          (held),
    .press_count   (press_count)
  );

  button_event_decoder #(
    .LONG_CYCLES   (LONG),
    .REPEAT_CYCLES (REP),
    .REPEAT_EN     (1'b0),
    .CNT_W         (8)
  ) dut_norep (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn           (btn2),
    .press_pulse   (p2),
    .release_pulse (r2),
    .short_pulse   (s2),
    .long_pulse    (l2),
    .repeat_pulse  (rp2),
    .held          (h2),
    .press_count   (c2)
  );

  task automatic push(input int c, input int k);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    exp_q.push_back(e);
  endtask

  // Advance one clock, then match observed pulses of the main DUT against the queue.
  task automatic tick();
    logic [4:0] obs;
    int hc, hk;
    @(negedge clk);
    ecnt++;
    obs = {repeat_pulse, long_pulse, short_pulse, release_pulse, press_pulse};
    while (exp_q.size() > 0 && exp_q[0].cyc < ecnt) begin
      nvec++;
      nerr++;
      $display("FAIL missed_event kind=%0d: expected at cycle %0d, not observed by cycle %0d",
               exp_q[0].kind, exp_q[0].cyc, ecnt);
      void'(exp_q.pop_front());
    end
    for (int k = 0; k < 5; k++) begin
      if (obs[k]) begin
        nvec++;
        hc = (exp_q.size() > 0) ? exp_q[0].cyc : -1;
        hk = (exp_q.size() > 0) ? exp_q[0].kind : -1;
        if (hc != ecnt || hk != k) begin
          nerr++;
          $display("FAIL unexpected_event: got kind=%0d at cycle %0d, expected kind=%0d at cycle %0d",
                   k, ecnt, hk, hc);
        end else begin
          void'(exp_q.pop_front());
        end
      end
    end
    if (p2)  n2[K_PRESS]++;
    if (r2)  n2[K_REL]++;
    if (s2)  n2[K_SHORT]++;
    if (l2)  n2[K_LONG]++;
    if (rp2) n2[K_REP]++;
  endtask

  // One press of L cycles from idle; queues all events it should cause.
  task automatic run_press(input int L, input int exp_count);
    int e, p, r;
    e = ecnt;
    p = e + 2;
    r = p + L;
    push(p, K_PRESS);
    if (L > LONG) begin
      push(p + LONG, K_LONG);
      for (int t = p + LONG + REP; t < r; t += REP) push(t, K_REP);
    end
    push(r, K_REL);
    if (L <= LONG) push(r, K_SHORT);
    for (int i = 0; i < L + 4; i++) begin
      btn = (i < L);
      tick();
      if (ecnt == p || ecnt == r - 1) begin
        nvec++;
        if (held !== 1'b1) begin
          nerr++;
          $display("FAIL held_during_press L=%0d cycle %0d: got %b, expected 1", L, ecnt, held);
        end
      end
      if (ecnt == r) begin
        nvec++;
        if (held !== 1'b0) begin
          nerr++;
          $display("FAIL held_after_release L=%0d cycle %0d: got %b, expected 0", L, ecnt, held);
        end
      end
    end
    nvec++;
    if (press_count !== 8'(exp_count)) begin
      nerr++;
      $display("FAIL press_count L=%0d: got %0d, expected %0d", L, press_count, exp_count);
    end
  endtask

  task automatic check_quiet(input string tag);
    nvec++;
    if ({press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held, press_count} !== 14'd0) begin
      nerr++;
      $display("FAIL %s cycle %0d: got pulses=%b held=%b count=%0d, expected all 0", tag, ecnt,
               {press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse}, held, press_count);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    btn   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_quiet("reset_active");
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_quiet("reset_released");
    end
  endtask

  task automatic test_short_click();
    run_press(3, 1);
  endtask

  task automatic test_long_repeat();
    run_press(21, 2);
  endtask

  task automatic test_tie();
    run_press(LONG, 3);
  endtask

  task automatic test_held_through_reset();
    int e;
    e = ecnt;
    push(e + 2, K_PRESS);
    btn = 1'b1;
    repeat (4) tick();
    nvec++;
    if (press_count !== 8'd4) begin
      nerr++;
      $display("FAIL press_count_before_reset: got %0d, expected 4", press_count);
    end
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_quiet("held_in_reset");
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_quiet("held_after_reset");
    end
    btn = 1'b0;
    repeat (3) tick();
    check_quiet("release_after_reset");
    run_press(3, 1);
  endtask

  task automatic test_wrap_back_to_back();
    int e;
    rst_n = 1'b0;
    btn   = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check_quiet("wrap_start");
    for (int i = 0; i < 256; i++) begin
      e = ecnt;
      if (i == 255) begin
        nvec++;
        if (press_count !== 8'd255) begin
          nerr++;
          $display("FAIL press_count_255: got %0d, expected 255", press_count);
        end
      end
      push(e + 2, K_PRESS);
      push(e + 3, K_REL);
      push(e + 3, K_SHORT);
      btn = 1'b1;
      tick();
      btn = 1'b0;
      tick();
    end
    repeat (4) tick();
    nvec++;
    if (press_count !== 8'd0) begin
      nerr++;
      $display("FAIL press_count_wrap: got %0d, expected 0", press_count);
    end
  endtask

  task automatic test_no_repeat();
    for (int k = 0; k < 5; k++) n2[k] = 0;
    for (int i = 0; i < 26; i++) begin
      btn2 = (i < 20);
      tick();
      if (i == 12) begin
        nvec++;
        if (h2 !== 1'b1) begin
          nerr++;
          $display("FAIL norep_held: got %b, expected 1", h2);
        end
      end
    end
    nvec++;
    if (n2[K_PRESS] != 1 || n2[K_REL] != 1 || n2[K_SHORT] != 0) begin
      nerr++;
      $display("FAIL norep_press_release: got press=%0d release=%0d short=%0d, expected 1/1/0",
               n2[K_PRESS], n2[K_REL], n2[K_SHORT]);
    end
    nvec++;
    if (n2[K_LONG] != 1) begin
      nerr++;
      $display("FAIL norep_long: got %0d, expected 1", n2[K_LONG]);
    end
    nvec++;
    if (n2[K_REP] != 0) begin
      nerr++;
      $display("FAIL norep_repeat: got %0d, expected 0", n2[K_REP]);
    end
    nvec++;
    if (h2 !== 1'b0 || c2 !== 8'd1) begin
      nerr++;
      $display("FAIL norep_final: got held=%b count=%0d, expected held=0 count=1", h2, c2);
    end
  endtask

  initial begin
    test_reset();
    test_short_click();
    test_long_repeat();
    test_tie();
    test_held_through_reset();
    test_wrap_back_to_back();
    test_no_repeat();
    repeat (5) tick();
    nvec++;
    if (exp_q.size() != 0) begin
      nerr++;
      $display("FAIL pending_events: got %0d still queued, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
